// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, control-field widths/bit positions and the MEM-stage FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned MEMCTRL_W = 5;
  localparam int unsigned WBCTRL_W  = 4;
  localparam int unsigned REG_W     = 5;

  // ex_MEMctrl bit positions; [4:3] are reserved
  localparam int unsigned MEM_DREN = 0;
  localparam int unsigned MEM_DWEN = 1;
  localparam int unsigned MEM_HALT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } memstate_t;

endpackage

// File: rtl/mem_stage_if.sv
// MEM-stage signal bundle: EX/MEM latch inputs, dcache port, pipeline control and MEM/WB outputs.
interface mem_stage_if;
  import cpu_types_pkg::*;

  logic                 ex_valid;
  logic [MEMCTRL_W-1:0] ex_MEMctrl;
  logic [WBCTRL_W-1:0]  ex_WBctrl;
  logic [REG_W-1:0]     ex_dest;
  word_t                ex_aluout;
  word_t                ex_store;
  word_t                ex_npc;
  word_t                ex_instr;
  logic                 ihit;

  logic                 dmemREN;
  logic                 dmemWEN;
  word_t                dmemaddr;
  word_t                dmemstore;
  word_t                dmemload;
  logic                 dhit;

  logic                 mem_stall;
  logic                 advance;

  logic                 wb_valid;
  logic [WBCTRL_W-1:0]  wb_WBctrl;
  logic [REG_W-1:0]     wb_dest;
  word_t                wb_aluout;
  word_t                wb_dmemload;
  word_t                wb_npc;
  word_t                wb_instr;
  logic                 halt;

  // Stage side
  modport slave (
    input  ex_valid, ex_MEMctrl, ex_WBctrl, ex_dest, ex_aluout, ex_store, ex_npc, ex_instr,
    input  ihit, dmemload, dhit,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, advance,
    output wb_valid, wb_WBctrl, wb_dest, wb_aluout, wb_dmemload, wb_npc, wb_instr, halt
  );

  // Environment side (pipeline + dcache)
  modport master (
    output ex_valid, ex_MEMctrl, ex_WBctrl, ex_dest, ex_aluout, ex_store, ex_npc, ex_instr,
    output ihit, dmemload, dhit,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, advance,
    input  wb_valid, wb_WBctrl, wb_dest, wb_aluout, wb_dmemload, wb_npc, wb_instr, halt
  );

endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues dcache requests, stalls upstream until dhit, and holds a completed
// access in a load buffer until the pipeline can advance so each store is performed once.
module mem_stage
  import cpu_types_pkg::*;
(
  input logic         CLK,
  input logic         RST,
  mem_stage_if.slave  mem_io
);

  memstate_t state_q, state_d;
  word_t     lbuf_q, lbuf_d;

  logic memop, req, dhit_live, stall, adv;

  logic                wb_valid_q;
  logic [WBCTRL_W-1:0] wb_wbctrl_q;
  logic [REG_W-1:0]    wb_dest_q;
  word_t               wb_aluout_q, wb_dmemload_q, wb_npc_q, wb_instr_q;
  logic                halt_q;

  // Request and stall decode
  always_comb begin
    memop = mem_io.ex_valid & (mem_io.ex_MEMctrl[MEM_DREN] | mem_io.ex_MEMctrl[MEM_DWEN]);
    req   = memop & (state_q != HOLD);
    // dhit only means something while a request is on the bus
    dhit_live = req & mem_io.dhit;
    stall     = req & ~mem_io.dhit;
    adv       = mem_io.ihit & ~stall;

    mem_io.dmemWEN   = req & mem_io.ex_MEMctrl[MEM_DWEN];
    mem_io.dmemREN   = req & mem_io.ex_MEMctrl[MEM_DREN] & ~mem_io.ex_MEMctrl[MEM_DWEN];
    mem_io.dmemaddr  = mem_io.ex_aluout;
    mem_io.dmemstore = mem_io.ex_store;
    mem_io.mem_stall = stall;
    mem_io.advance   = adv;
  end

  always_comb begin
    state_d = state_q;
    lbuf_d  = lbuf_q;
    unique case (state_q)
      IDLE: begin
        if (memop & ~mem_io.dhit) begin
          state_d = ACCESS;
        end else if (dhit_live & ~mem_io.ihit) begin
          state_d = HOLD;
          lbuf_d  = mem_io.dmemload;
        end
      end
      ACCESS: begin
        if (dhit_live & mem_io.ihit) begin
          state_d = IDLE;
        end else if (dhit_live & ~mem_io.ihit) begin
          state_d = HOLD;
          lbuf_d  = mem_io.dmemload;
        end
      end
      HOLD: begin
        if (mem_io.ihit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      lbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      lbuf_q  <= lbuf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_valid_q    <= 1'b0;
      wb_wbctrl_q   <= '0;
      wb_dest_q     <= '0;
      wb_aluout_q   <= '0;
      wb_dmemload_q <= '0;
      wb_npc_q      <= '0;
      wb_instr_q    <= '0;
      halt_q        <= 1'b0;
    end else if (adv) begin
      wb_valid_q    <= mem_io.ex_valid;
      wb_wbctrl_q   <= mem_io.ex_WBctrl;
      wb_dest_q     <= mem_io.ex_dest;
      wb_aluout_q   <= mem_io.ex_aluout;
      wb_dmemload_q <= dhit_live ? mem_io.dmemload : lbuf_q;
      wb_npc_q      <= mem_io.ex_npc;
      wb_instr_q    <= mem_io.ex_instr;
      if (mem_io.ex_valid & mem_io.ex_MEMctrl[MEM_HALT]) halt_q <= 1'b1;
    end
  end

  assign mem_io.wb_valid    = wb_valid_q;
  assign mem_io.wb_WBctrl   = wb_wbctrl_q;
  assign mem_io.wb_dest     = wb_dest_q;
  assign mem_io.wb_aluout   = wb_aluout_q;
  assign mem_io.wb_dmemload = wb_dmemload_q;
  assign mem_io.wb_npc      = wb_npc_q;
  assign mem_io.wb_instr    = wb_instr_q;
  assign mem_io.halt        = halt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: decode table, directed multi-cycle sequences, random vs model.
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_stage_if bus ();

  mem_stage dut (
    .CLK    (CLK),
    .RST    (RST),
    .mem_io (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       ex_valid;
    logic [4:0] memctrl;
    logic       dhit;
    logic       ihit;
    logic [3:0] exp;  // {dmemREN, dmemWEN, mem_stall, advance}
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    bus.ex_valid   = 1'b0;
    bus.ex_MEMctrl = '0;
    bus.ex_WBctrl  = '0;
    bus.ex_dest    = '0;
    bus.ex_aluout  = '0;
    bus.ex_store   = '0;
    bus.ex_npc     = '0;
    bus.ex_instr   = '0;
    bus.ihit       = 1'b0;
    bus.dhit       = 1'b0;
    bus.dmemload   = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  function automatic logic [3:0] comb_outs();
    return {bus.dmemREN, bus.dmemWEN, bus.mem_stall, bus.advance};
  endfunction

  // Reference model state: 'served' means the access has completed but not yet transferred
  logic  m_served, m_halt, m_wb_valid;
  word_t m_buf, m_wb_aluout, m_wb_dml;

  initial begin
    logic [4:0] wen_mask, stall_mask, adv_mask;
    int         stall_cnt, ren_cnt;
    logic       new_instr;

    vecs[0] = '{"alu_ihit",    1'b1, 5'b00000, 1'b0, 1'b1, 4'b0001};
    vecs[1] = '{"alu_noihit",  1'b1, 5'b00000, 1'b0, 1'b0, 4'b0000};
    vecs[2] = '{"ld_miss",     1'b1, 5'b00001, 1'b0, 1'b1, 4'b1010};
    vecs[3] = '{"ld_hit",      1'b1, 5'b00001, 1'b1, 1'b1, 4'b1001};
    vecs[4] = '{"ld_hit_noih", 1'b1, 5'b00001, 1'b1, 1'b0, 4'b1000};
    vecs[5] = '{"st_miss",     1'b1, 5'b00010, 1'b0, 1'b1, 4'b0110};
    vecs[6] = '{"rw_is_write", 1'b1, 5'b00011, 1'b1, 1'b1, 4'b0101};
    vecs[7] = '{"invalid_ld",  1'b0, 5'b00001, 1'b1, 1'b1, 4'b0001};

    set_idle();
    do_reset();
    check("reset_state", dut.state_q, IDLE);
    check("reset_wb_valid", bus.wb_valid, 1'b0);
    check("reset_halt", bus.halt, 1'b0);
    check("reset_wb_dmemload", bus.wb_dmemload, 32'h0);

    // Decode table, each row from a fresh IDLE
    for (int i = 0; i < 8; i++) begin
      set_idle();
      do_reset();
      bus.ex_valid   = vecs[i].ex_valid;
      bus.ex_MEMctrl = vecs[i].memctrl;
      bus.ex_aluout  = 32'h100 + 32'(i);
      bus.dhit       = vecs[i].dhit;
      bus.ihit       = vecs[i].ihit;
      #1;
      check(vecs[i].name, comb_outs(), vecs[i].exp);
    end

    // ALU instruction transfers on first ihit
    set_idle();
    do_reset();
    bus.ex_valid  = 1'b1;
    bus.ex_aluout = 32'h10;
    bus.ex_dest   = 5'd3;
    bus.ex_WBctrl = 4'h5;
    bus.ihit      = 1'b1;
    #1;
    check("alu_stall", bus.mem_stall, 1'b0);
    check("alu_ren", bus.dmemREN, 1'b0);
    tick();
    check("alu_wb_aluout", bus.wb_aluout, 32'h10);
    check("alu_wb_valid", bus.wb_valid, 1'b1);
    check("alu_wb_dest", bus.wb_dest, 5'd3);
    check("alu_wb_wbctrl", bus.wb_WBctrl, 4'h5);

    // Load with dhit arriving in the 4th cycle
    set_idle();
    do_reset();
    bus.ex_valid   = 1'b1;
    bus.ex_MEMctrl = 5'b00001;
    bus.ex_aluout  = 32'h40;
    bus.ihit       = 1'b1;
    stall_cnt = 0;
    ren_cnt   = 0;
    for (int c = 1; c <= 4; c++) begin
      bus.dhit     = (c == 4);
      bus.dmemload = (c == 4) ? 32'hCAFE : 32'h0;
      #1;
      if (bus.mem_stall) stall_cnt++;
      if (bus.dmemREN) ren_cnt++;
      if (c == 1) check("ld_addr", bus.dmemaddr, 32'h40);
      tick();
    end
    set_idle();
    check("ld_stall_cycles", 64'(stall_cnt), 64'd3);
    check("ld_ren_cycles", 64'(ren_cnt), 64'd4);
    check("ld_wb_dmemload", bus.wb_dmemload, 32'hCAFE);
    check("ld_wb_valid", bus.wb_valid, 1'b1);

    // Store completes in cycle 2, ihit held off until cycle 5
    set_idle();
    do_reset();
    bus.ex_valid   = 1'b1;
    bus.ex_MEMctrl = 5'b00010;
    bus.ex_aluout  = 32'h80;
    bus.ex_store   = 32'h1234;
    wen_mask   = '0;
    stall_mask = '0;
    adv_mask   = '0;
    for (int c = 1; c <= 5; c++) begin
      bus.dhit = (c == 2);
      bus.ihit = (c == 5);
      #1;
      wen_mask[c-1]   = bus.dmemWEN;
      stall_mask[c-1] = bus.mem_stall;
      adv_mask[c-1]   = bus.advance;
      if (c == 1) check("st_data", bus.dmemstore, 32'h1234);
      if (c >= 3) check("st_hold_state", dut.state_q, HOLD);
      tick();
    end
    check("st_wen_mask", wen_mask, 5'b00011);
    check("st_stall_mask", stall_mask, 5'b00001);
    check("st_adv_mask", adv_mask, 5'b10000);
    check("st_after_state", dut.state_q, IDLE);
    check("st_wb_valid", bus.wb_valid, 1'b1);
    set_idle();

    // Load with dhit and ihit together in IDLE
    do_reset();
    bus.ex_valid   = 1'b1;
    bus.ex_MEMctrl = 5'b00001;
    bus.ex_aluout  = 32'h44;
    bus.dhit       = 1'b1;
    bus.ihit       = 1'b1;
    bus.dmemload   = 32'hBEEF;
    #1;
    check("ldfast_outs", comb_outs(), 4'b1001);
    tick();
    set_idle();
    check("ldfast_wb_dmemload", bus.wb_dmemload, 32'hBEEF);
    check("ldfast_state", dut.state_q, IDLE);

    // Sticky halt
    do_reset();
    bus.ex_valid   = 1'b1;
    bus.ex_MEMctrl = 5'b00100;
    bus.ihit       = 1'b1;
    tick();
    set_idle();
    check("halt_set", bus.halt, 1'b1);
    for (int c = 0; c < 10; c++) tick();
    check("halt_sticky", bus.halt, 1'b1);
    do_reset();
    check("halt_reset", bus.halt, 1'b0);

    // Reset in the middle of an access
    set_idle();
    do_reset();
    bus.ex_valid = 1'b1;
    bus.ihit     = 1'b1;
    tick();
    bus.ex_MEMctrl = 5'b00001;
    bus.ex_aluout  = 32'h60;
    tick();
    check("rst_acc_state", dut.state_q, ACCESS);
    check("rst_acc_wbv_pre", bus.wb_valid, 1'b1);
    RST = 1'b1;
    bus.ex_valid = 1'b0;
    tick();
    RST = 1'b0;
    #1;
    check("rst_acc_state_post", dut.state_q, IDLE);
    check("rst_acc_wbv_post", bus.wb_valid, 1'b0);
    check("rst_acc_ren", bus.dmemREN, 1'b0);

    // Random traffic against the transaction model
    set_idle();
    do_reset();
    m_served = 1'b0; m_halt = 1'b0; m_wb_valid = 1'b0;
    m_buf = '0; m_wb_aluout = '0; m_wb_dml = '0;
    new_instr = 1'b1;
    for (int c = 0; c < 600; c++) begin
      logic memop, rd, wr, req, stall, adv;
      if (new_instr) begin
        bus.ex_valid   = ($urandom % 4) != 0;
        bus.ex_MEMctrl = 5'($urandom_range(0, 31)) & 5'b11011;
        if ($urandom % 40 == 0) bus.ex_MEMctrl[2] = 1'b1;
        bus.ex_aluout  = $urandom;
        bus.ex_store   = $urandom;
        bus.ex_npc     = $urandom;
        bus.ex_instr   = $urandom;
        bus.ex_WBctrl  = 4'($urandom);
        bus.ex_dest    = 5'($urandom);
      end
      bus.dhit     = ($urandom % 3) == 0;
      bus.ihit     = ($urandom % 4) != 0;
      bus.dmemload = $urandom;
      #1;
      wr    = bus.ex_MEMctrl[1];
      rd    = bus.ex_MEMctrl[0] & ~wr;
      memop = bus.ex_valid & (rd | wr);
      req   = memop & ~m_served;
      stall = req & ~bus.dhit;
      adv   = bus.ihit & ~stall;
      check("rnd_ctrl", comb_outs(), {req & rd, req & wr, stall, adv});
      if (req) check("rnd_addr", bus.dmemaddr, bus.ex_aluout);
      if (adv) begin
        m_wb_valid  = bus.ex_valid;
        m_wb_aluout = bus.ex_aluout;
        m_wb_dml    = (req & bus.dhit) ? bus.dmemload : m_buf;
        if (bus.ex_valid & bus.ex_MEMctrl[2]) m_halt = 1'b1;
        m_served = 1'b0;
      end else if (req & bus.dhit) begin
        m_served = 1'b1;
        m_buf    = bus.dmemload;
      end
      new_instr = adv;
      tick();
      check("rnd_wb_valid", bus.wb_valid, m_wb_valid);
      check("rnd_wb_aluout", bus.wb_aluout, m_wb_aluout);
      check("rnd_wb_dmemload", bus.wb_dmemload, m_wb_dml);
      check("rnd_halt", bus.halt, m_halt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port CLK, input, 1, single system clock, all state on rising edge.
REQ-002 SHALL have port RST, input, 1, synchronous active-high reset: one clock, reset is synchronous and active-high.
REQ-003 SHALL have port ex_valid, input, 1, EX/MEM latch holds a live instruction.
REQ-004 SHALL have ports ex_MEMctrl (in, 5: [0]=dREN, [1]=dWEN, [2]=halt, [4:3] reserved), ex_WBctrl (in, 4), ex_dest (in, 5) and ex_aluout/ex_store/ex_npc/ex_instr (in, 32 each), all EX/MEM latch outputs.
REQ-005 SHALL have port ihit, input, 1, fetch ready / global pipeline advance qualifier.
REQ-006 SHALL have dcache ports dmemREN (out, 1), dmemWEN (out, 1), dmemaddr (out, 32), dmemstore (out, 32), dmemload (in, 32) and dhit (in, 1).
REQ-007 SHALL have port mem_stall, output, 1, freezes all upstream latches.
REQ-008 SHALL have port advance, output, 1, equal to ihit & ~mem_stall; the common enable for EX/MEM and MEM/WB.
REQ-009 SHALL have MEM/WB outputs wb_valid (1), wb_WBctrl (4), wb_dest (5), wb_aluout (32), wb_dmemload (32), wb_npc (32) and wb_instr (32), all registered.
REQ-010 SHALL have port halt, output, 1, sticky processor-halt flag, registered.

Function
REQ-011 SHALL define memop = ex_valid & (dREN | dWEN); dREN and dWEN both set SHALL be treated as a write only.
REQ-012 SHALL implement FSM states IDLE, ACCESS and HOLD.
REQ-013 SHALL, in IDLE or ACCESS with memop, drive dmemREN/dmemWEN from ex_MEMctrl, dmemaddr = ex_aluout and dmemstore = ex_store, combinationally.
REQ-014 SHALL hold dmemREN = dmemWEN = 0 in HOLD and whenever memop = 0.
REQ-015 SHALL assert mem_stall = memop & ~dhit & (state != HOLD); it SHALL be 0 otherwise.
REQ-016 SHALL make the following IDLE transitions: memop & ~dhit -> ACCESS; memop & dhit & ~ihit -> HOLD, capturing dmemload into the load buffer; else stay IDLE.
REQ-017 SHALL make the following ACCESS transitions: dhit & ihit -> IDLE; dhit & ~ihit -> HOLD, capturing dmemload; ~dhit -> stay ACCESS.
REQ-018 SHALL leave HOLD only on ihit -> IDLE, so a store completes exactly once.
REQ-019 SHALL, on advance, load the MEM/WB register: wb_valid = ex_valid and all other wb_* fields from the ex_* inputs.
REQ-020 SHALL take wb_dmemload from dmemload when dhit is high in that cycle, else from the load buffer.
REQ-021 SHALL hold all wb_* values when advance = 0; wb_valid SHALL NOT be cleared by a stall.
REQ-022 SHALL ignore dhit while no request is driven.
REQ-023 SHALL set halt on advance when ex_valid & ex_MEMctrl[2], and hold it at 1 until RST.
REQ-024 SHALL give non-memory instructions 0 added latency: they transfer on the first ihit.
REQ-025 SHALL give memory instructions latency equal to dhit arrival plus any ihit wait.

Reset
REQ-026 SHALL, while RST is high at a clock edge, set state = IDLE, load buffer = 0, every wb_* = 0 and halt = 0.
REQ-027 SHALL, on RST mid-ACCESS or mid-HOLD, abandon the access; no request SHALL be driven in the cycle after reset is applied unless memop is present again.

Structure
REQ-028 SHALL take the MEMctrl bit indices, the WBctrl width and the state enum (IDLE, ACCESS, HOLD) from cpu_types_pkg; word_t SHALL be used for all 32-bit fields.
REQ-029 SHALL be implemented as one module with no sub-modules.
REQ-030 SHALL place the FSM and load buffer in one clocked process, with the request and stall decode in one combinational process.

Verification
REQ-031 SHALL cover: ALU instruction (MEMctrl=0, aluout=0x10, ihit=1) -> mem_stall=0, dmemREN=0, and next cycle wb_aluout=0x10, wb_valid=1.
REQ-032 SHALL cover: load with addr 0x40 and dhit 3 cycles later (dmemload=0xCAFE, ihit=1) -> mem_stall high for 3 cycles, dmemREN=1 for 4 cycles, and wb_dmemload=0xCAFE after the 4th edge.
REQ-033 SHALL cover: store with addr 0x80, data 0x1234, dhit on cycle 2 with ihit low until cycle 5 -> dmemWEN=1 only in cycles 1-2, state HOLD in cycles 3-5, mem_stall=0 in HOLD, and no second write.
REQ-034 SHALL cover: load where dhit and ihit rise together in IDLE -> single-cycle transfer and wb_dmemload equal to the live dmemload.
REQ-035 SHALL cover: halt instruction with ihit=1 -> halt=1 next cycle, still 1 after 10 idle cycles, and 0 only after RST.
REQ-036 SHALL cover: RST asserted during ACCESS -> next cycle state IDLE, wb_valid=0, and dmemREN=0 with ex_valid=0.
